// File: rtl/fetch_queue_pkg.sv
// Shared processor definitions for the fetch front end.
// XLEN, reset PC, NOP encoding, fetch FSM states and queue entry layout.
package fetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_WAIT = 2'd1,
        FQ_DROP = 2'd2
    } fq_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] a
    );
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries.
// Clear wins over push/pop; DEPTH must be a power of two.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  fq_entry_t       wdata,
    output fq_entry_t       head,
    output logic [CW-1:0]   count
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    fq_entry_t     mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one-outstanding request FSM, PC and FIFO.
// Optional FETCH_QUEUE_BYPASS_EN forwards an ack straight to the head.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [CW-1:0]   count
);

    fq_state_t       state;
    fq_state_t       state_nx;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic            issue;
    logic            accept;
    logic            push;
    logic            pop;
    logic            head_valid;
    fq_entry_t       head;
    fq_entry_t       wdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    // Only an IDLE FSM issues, so count alone bounds the credit.
    always_comb begin
        head_valid = (count != '0);
        issue = rst && (state == FQ_IDLE) && !redirect
              && (count < CW'(DEPTH));
        imem_req  = issue || (state != FQ_IDLE);
        imem_addr = (state == FQ_IDLE) ? fetch_pc : req_addr;
        accept = imem_ack && (state == FQ_WAIT) && !redirect;
        pop    = head_valid && !stall && !redirect;
        push   = accept;
        wdata.pc    = req_addr;
        wdata.instr = imem_rdata;
        instr_valid = head_valid;
        instr    = head_valid ? head.instr : NOP;
        instr_pc = head_valid ? head.pc : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (accept && !head_valid) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = req_addr;
            push        = stall;
        end
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FQ_IDLE: begin
                if (issue) begin
                    state_nx = FQ_WAIT;
                end
            end
            FQ_WAIT: begin
                if (imem_ack) begin
                    state_nx = FQ_IDLE;
                end else if (redirect) begin
                    state_nx = FQ_DROP;
                end
            end
            FQ_DROP: begin
                if (imem_ack) begin
                    state_nx = FQ_IDLE;
                end
            end
            default: state_nx = FQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FQ_IDLE;
            fetch_pc <= word_align(RESET_PC);
            req_addr <= word_align(RESET_PC);
        end else begin
            state <= state_nx;
            if (issue) begin
                req_addr <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= word_align(redirect_pc);
            end else if (accept) begin
                fetch_pc <= req_addr + XLEN'(4);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-level fetch model.
// Memory model answers each accepted request after a random latency.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  count;

    int npass = 0;
    int ntot  = 0;

    ent_t        q[$];
    bit          m_out;
    bit          m_live;
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_dly;
    int          lat_min = 1;
    int          lat_max = 1;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        q.delete();
        m_out = 0;
        m_live = 0;
        m_pc = 32'h0;
        m_req_pc = 32'h0;
        mem_pend = 0;
        mem_dly = 0;
        repeat (2) @(posedge clk);
        #1;
        ntot++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || count !== 3'd0
            || instr !== 32'h0 || instr_pc !== 32'h0) begin
            $display("FAIL reset_state: req=%b v=%b cnt=%0d ins=%h pc=%h want 0",
                     imem_req, instr_valid, count, instr, instr_pc);
        end else begin
            npass++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        ntot++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            $display("FAIL first_req: req=%b addr=%h want 1 %h",
                     imem_req, imem_addr, m_pc);
        end else begin
            npass++;
        end
    endtask

    task automatic step(input bit st, input bit rd,
                        input logic [31:0] rpc, input bit stray);
        bit          ack;
        bit          mem_ack;
        bit          exp_req;
        bit          issued;
        bit          live_ack;
        bit          byp;
        logic [31:0] rdata;
        ent_t        e;
        mem_ack = mem_pend && (mem_dly == 0);
        ack = mem_ack || stray;
        rdata = mem_ack ? mdata(mem_addr) : $urandom;
        stall = st;
        redirect = rd;
        redirect_pc = rpc;
        imem_ack = ack;
        imem_rdata = rdata;
        #1;
        exp_req = m_out || (!rd && q.size() < DEPTH);
        ntot++;
        if (imem_req !== exp_req) begin
            $display("FAIL imem_req: got %b want %b", imem_req, exp_req);
        end else begin
            npass++;
        end
        if (m_out || exp_req) begin
            ntot++;
            if (imem_addr !== (m_out ? m_req_pc : m_pc)) begin
                $display("FAIL imem_addr: got %h want %h",
                         imem_addr, m_out ? m_req_pc : m_pc);
            end else begin
                npass++;
            end
        end
        live_ack = ack && m_out && m_live;
        byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (live_ack && !rd && q.size() == 0) begin
            ntot++;
            if (instr_valid !== 1'b1 || instr !== rdata || instr_pc !== m_req_pc) begin
                $display("FAIL bypass: v=%b ins=%h pc=%h want 1 %h %h",
                         instr_valid, instr, instr_pc, rdata, m_req_pc);
            end else begin
                npass++;
            end
            byp = !st;
        end
`endif
        issued = !m_out && exp_req;
        if (mem_pend) begin
            if (mem_dly == 0) mem_pend = 0;
            else mem_dly--;
        end
        if (issued) begin
            mem_pend = 1;
            mem_addr = imem_addr;
            mem_dly = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        if (rd) begin
            q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            if (m_out && !ack) m_live = 0;
        end else begin
            if (q.size() > 0 && !st) void'(q.pop_front());
            if (live_ack) begin
                e.pc = m_req_pc;
                e.ins = rdata;
                if (!byp) q.push_back(e);
                m_pc = m_req_pc + 32'd4;
            end
        end
        if (m_out && ack) m_out = 0;
        if (issued) begin
            m_out = 1;
            m_live = 1;
            m_req_pc = m_pc;
        end
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        redirect = 1'b0;
        #1;
        ntot++;
        if (count !== 3'(q.size())) begin
            $display("FAIL count: got %0d want %0d", count, q.size());
        end else begin
            npass++;
        end
        ntot++;
        if (q.size() == 0) begin
            if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
                $display("FAIL head_empty: v=%b ins=%h pc=%h want 0",
                         instr_valid, instr, instr_pc);
            end else begin
                npass++;
            end
        end else begin
            if (instr_valid !== 1'b1 || instr !== q[0].ins || instr_pc !== q[0].pc) begin
                $display("FAIL head: v=%b ins=%h pc=%h want 1 %h %h",
                         instr_valid, instr, instr_pc, q[0].ins, q[0].pc);
            end else begin
                npass++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_sequential();
        lat_min = 1;
        lat_max = 1;
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 0, 32'h0, 0);
        ntot++;
        if (m_pc < 32'd16) begin
            $display("FAIL seq_progress: fetch pc %h want >= 10", m_pc);
        end else begin
            npass++;
        end
    endtask

    task automatic test_full();
        lat_min = 1;
        lat_max = 1;
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 32'h0, 0);
        ntot++;
        if (count !== 3'd4 || imem_req !== 1'b0) begin
            $display("FAIL full: cnt=%0d req=%b want 4 0", count, imem_req);
        end else begin
            npass++;
        end
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        ntot++;
        if (count !== 3'd4 || instr_pc !== 32'h0) begin
            $display("FAIL stray_ack: cnt=%0d pc=%h want 4 0", count, instr_pc);
        end else begin
            npass++;
        end
        step(0, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        ntot++;
        if (instr_pc !== 32'h4) begin
            $display("FAIL pop_after_full: pc=%h want 4", instr_pc);
        end else begin
            npass++;
        end
    endtask

    task automatic test_redirect_drop();
        int i;
        lat_min = 3;
        lat_max = 3;
        do_reset();
        for (i = 0; i < 40 && !(m_out && m_req_pc == 32'h8); i++) step(0, 0, 32'h0, 0);
        ntot++;
        if (!(m_out && m_req_pc == 32'h8)) begin
            $display("FAIL drop_setup: no request to 8 within %0d cycles", i);
        end else begin
            npass++;
        end
        step(0, 1, 32'h100, 0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        ntot++;
        if (count !== 3'd0 || instr_valid !== 1'b0
            || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            $display("FAIL drop: cnt=%0d v=%b req=%b addr=%h want 0 0 1 100",
                     count, instr_valid, imem_req, imem_addr);
        end else begin
            npass++;
        end
        for (int k = 0; k < 8; k++) step(0, 0, 32'h0, 0);
    endtask

    task automatic test_redirect_ack_pop();
        int i;
        lat_min = 1;
        lat_max = 1;
        do_reset();
        for (i = 0; i < 30 && !(q.size() == 2 && m_out); i++) step(1, 0, 32'h0, 0);
        ntot++;
        if (!(q.size() == 2 && m_out)) begin
            $display("FAIL rap_setup: count 2 with request not reached in %0d", i);
        end else begin
            npass++;
        end
        step(0, 1, 32'h203, 0);
        ntot++;
        if (count !== 3'd0 || instr_valid !== 1'b0
            || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            $display("FAIL redir_ack_pop: cnt=%0d v=%b req=%b addr=%h want 0 0 1 200",
                     count, instr_valid, imem_req, imem_addr);
        end else begin
            npass++;
        end
    endtask

    task automatic test_wrap();
        int i;
        lat_min = 1;
        lat_max = 1;
        do_reset();
        step(1, 1, 32'hFFFF_FFFE, 0);
        for (i = 0; i < 20 && q.size() == 0; i++) step(1, 0, 32'h0, 0);
        ntot++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC
            || instr !== mdata(32'hFFFF_FFFC)) begin
            $display("FAIL wrap_entry: v=%b pc=%h ins=%h want 1 fffffffc %h",
                     instr_valid, instr_pc, instr, mdata(32'hFFFF_FFFC));
        end else begin
            npass++;
        end
        ntot++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            $display("FAIL wrap_addr: req=%b addr=%h want 1 0", imem_req, imem_addr);
        end else begin
            npass++;
        end
        for (int k = 0; k < 6; k++) step(0, 0, 32'h0, 0);
    endtask

    task automatic test_random();
        bit          st;
        bit          rd;
        logic [31:0] rpc;
        lat_min = 1;
        lat_max = 4;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(99, 0) < 35);
            rd = ($urandom_range(99, 0) < 6);
            rpc = $urandom;
            step(st, rd, rpc, 0);
        end
    endtask

    task automatic test_async_reset();
        lat_min = 1;
        lat_max = 2;
        for (int i = 0; i < 10; i++) step(1, 0, 32'h0, 0);
        ntot++;
        if (count === 3'd0) begin
            $display("FAIL areset_setup: cnt=%0d want nonzero", count);
        end else begin
            npass++;
        end
        #2;
        rst = 1'b0;
        #1;
        ntot++;
        if (count !== 3'd0 || instr_valid !== 1'b0 || instr !== 32'h0
            || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
            $display("FAIL async_reset: cnt=%0d v=%b ins=%h pc=%h req=%b want 0",
                     count, instr_valid, instr, instr_pc, imem_req);
        end else begin
            npass++;
        end
        do_reset();
        for (int i = 0; i < 12; i++) step(0, 0, 32'h0, 0);
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_sequential();
        test_full();
        test_redirect_drop();
        test_redirect_ack_pop();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
